// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm
// Control sequencer for the register-file/ALU datapath with load/store,
// HALT and illegal-instruction trapping. Decodes {opcode,op} after a start
// pulse and walks the datapath through the steps of that instruction.
//
// Handshake: w=1 means the sequencer is idle in WAIT and will accept a start.
// A rising edge that sees s=1 while w=1 commits the instruction currently on
// {opcode,op}. The instruction register must hold those fields stable until
// w returns to 1. s is ignored whenever w=0.
//
// Parameters:
//   MEM_WAIT  read-latency cycles spent in MEM_RD (1..15)
//   HALT_EN   1: opcode 111 halts; 0: opcode 111 traps to ERR
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   s                 start (sampled only in WAIT)
//   opcode, op        instruction fields
//   w                 idle / ready for the next instruction
//   nsel              one-hot register select (001 Rn, 010 Rd, 100 Rm)
//   vsel              writeback source (00 C, 01 mdata, 10 sximm8)
//   write, loada, loadb, loadc, loads, load_addr   datapath strobes
//   asel, bsel        A forced to zero / B from sximm5
//   mem_cmd           00 none, 01 read, 10 write
//   halted, err       sitting in HALT / ERR
//   dbg_state         current state encoding, for observation only
module cpu_ctrl_fsm #(
  parameter int   MEM_WAIT = 1,
  parameter logic HALT_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       load_addr,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] mem_cmd,
  output logic       halted,
  output logic       err,
  output logic [3:0] dbg_state
);

  localparam logic [3:0] S_WAIT    = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MOV_IMM = 4'd2;
  localparam logic [3:0] S_GET_A   = 4'd3;
  localparam logic [3:0] S_GET_B   = 4'd4;
  localparam logic [3:0] S_EXEC    = 4'd5;
  localparam logic [3:0] S_WB      = 4'd6;
  localparam logic [3:0] S_ADDR    = 4'd7;
  localparam logic [3:0] S_LADDR   = 4'd8;
  localparam logic [3:0] S_MEM_RD  = 4'd9;
  localparam logic [3:0] S_WB_MEM  = 4'd10;
  localparam logic [3:0] S_GET_D   = 4'd11;
  localparam logic [3:0] S_STR_EX  = 4'd12;
  localparam logic [3:0] S_MEM_WR  = 4'd13;
  localparam logic [3:0] S_HALT    = 4'd14;
  localparam logic [3:0] S_ERR     = 4'd15;

  localparam logic [4:0] I_MOV_IMM = 5'b11010;
  localparam logic [4:0] I_MOV_SH  = 5'b11000;
  localparam logic [4:0] I_MVN     = 5'b10111;
  localparam logic [4:0] I_ADD     = 5'b10100;
  localparam logic [4:0] I_CMP     = 5'b10101;
  localparam logic [4:0] I_AND     = 5'b10110;
  localparam logic [4:0] I_LDR     = 5'b01100;
  localparam logic [4:0] I_STR     = 5'b10000;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] cnt;
  logic [4:0] ins;

  assign ins       = {opcode, op};
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:    if (s) state_nxt = S_DECODE;
      S_DECODE: begin
        casez (ins)
          I_MOV_IMM:                      state_nxt = S_MOV_IMM;
          I_MOV_SH, I_MVN:                state_nxt = S_GET_B;
          I_ADD, I_CMP, I_AND:            state_nxt = S_GET_A;
          I_LDR, I_STR:                   state_nxt = S_GET_A;
          5'b111??:                       state_nxt = HALT_EN ? S_HALT : S_ERR;
          default:                        state_nxt = S_ERR;
        endcase
      end
      S_MOV_IMM: state_nxt = S_WAIT;
      S_GET_A:   state_nxt = (ins == I_LDR || ins == I_STR) ? S_ADDR : S_GET_B;
      S_GET_B:   state_nxt = S_EXEC;
      S_EXEC:    state_nxt = (ins == I_CMP) ? S_WAIT : S_WB;
      S_WB:      state_nxt = S_WAIT;
      S_ADDR:    state_nxt = S_LADDR;
      // Only LDR and STR reach LADDR, so anything but LDR is a store.
      S_LADDR:   state_nxt = (ins == I_LDR) ? S_MEM_RD : S_GET_D;
      S_MEM_RD:  if (cnt == 4'd0) state_nxt = S_WB_MEM;
      S_WB_MEM:  state_nxt = S_WAIT;
      S_GET_D:   state_nxt = S_STR_EX;
      S_STR_EX:  state_nxt = S_MEM_WR;
      S_MEM_WR:  state_nxt = S_WAIT;
      S_HALT:    state_nxt = S_HALT;
      S_ERR:     state_nxt = S_ERR;
      default:   state_nxt = S_ERR;
    endcase
  end

  // The wait counter is loaded on the way into MEM_RD and counts down
  // while there; its value elsewhere is never looked at.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == S_LADDR && state_nxt == S_MEM_RD)
        cnt <= WAIT_INIT;
      else if (state == S_MEM_RD)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    w         = 1'b0;
    nsel      = 3'b000;
    vsel      = 2'b00;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    load_addr = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    mem_cmd   = 2'b00;
    halted    = 1'b0;
    err       = 1'b0;
    case (state)
      S_WAIT:    w = 1'b1;
      S_MOV_IMM: begin nsel = 3'b001; vsel = 2'b10; write = 1'b1; end
      S_GET_A:   begin nsel = 3'b001; loada = 1'b1; end
      S_GET_B:   begin nsel = 3'b100; loadb = 1'b1; end
      S_EXEC: begin
        loadc = 1'b1;
        // MOV shift and MVN pass B through the ALU with A forced to zero.
        asel  = (ins == I_MOV_SH || ins == I_MVN);
        loads = (ins == I_CMP);
      end
      S_WB:      begin nsel = 3'b010; write = 1'b1; end
      S_ADDR:    begin bsel = 1'b1; loadc = 1'b1; end
      S_LADDR:   load_addr = 1'b1;
      S_MEM_RD:  mem_cmd = 2'b01;
      // Keep the read command up while mdata is written back.
      S_WB_MEM:  begin mem_cmd = 2'b01; nsel = 3'b010; vsel = 2'b01; write = 1'b1; end
      S_GET_D:   begin nsel = 3'b010; loadb = 1'b1; end
      S_STR_EX:  begin asel = 1'b1; loadc = 1'b1; end
      S_MEM_WR:  mem_cmd = 2'b10;
      S_HALT:    halted = 1'b1;
      S_ERR:     err = 1'b1;
      default:   ;
    endcase
  end

endmodule
